// File: rtl/ov5640_init_sequencer_if.sv
// ---------------------------------------------------------------------------
// ov5640_init_sequencer_if
//
// Purpose:
//   Write channel between the OV5640 init sequencer and the SCCB write
//   master. Only one write is in flight at a time. The requester raises
//   req with addr/data and holds all three until the master pulses done.
//   err is sampled together with done.
//
// Signals:
//   req   requester -> master  write request, held until done
//   addr  requester -> master  16-bit camera register address
//   data  requester -> master  8-bit register value
//   done  master -> requester  one-cycle pulse, the current write finished
//   err   master -> requester  valid with done, 1 = NACK or failed write
//
// Modports:
//   master  the side that issues writes (the init sequencer)
//   slave   the side that performs them (the SCCB write master)
// ---------------------------------------------------------------------------
interface ov5640_init_sequencer_if;
  logic        req;
  logic [15:0] addr;
  logic [7:0]  data;
  logic        done;
  logic        err;

  modport master (
    output req,
    output addr,
    output data,
    input  done,
    input  err
  );

  modport slave (
    input  req,
    input  addr,
    input  data,
    output done,
    output err
  );
endinterface

// File: rtl/ov5640_init_sequencer.sv
// ---------------------------------------------------------------------------
// ov5640_init_sequencer
//
// Purpose:
//   Walks the OV5640 init register ROM from index 0 to INIT_NUM-1 after a
//   start pulse. Each 24-bit entry {reg_addr[15:0], reg_data[7:0]} is passed
//   to the SCCB write master one write at a time. The sequencer adds a
//   power-up wait before the first fetch and a settle wait after a software
//   reset write (0x3008 with bit 7 set). A failed write is retried a bounded
//   number of times. The result is reported as a done or error level.
//
// Ports:
//   clk        system clock
//   rst        asynchronous reset, active-high
//   start      one-cycle pulse, accepted in IDLE, DONE and ERR only
//   rom_addr   ROM index; rom_q is valid one cycle after it changes
//   rom_q      ROM data {reg_addr[15:0], reg_data[7:0]}
//   sccb       write channel to the SCCB master (master modport)
//   busy       high in every state except IDLE, DONE and ERR
//   init_done  level, high in DONE
//   init_err   level, high in ERR
//   err_index  ROM index of the entry that used up its retries
// ---------------------------------------------------------------------------
module ov5640_init_sequencer #(
  parameter int          ADDR_WIDTH   = 8,
  parameter int          INIT_NUM     = 86,
  parameter logic [19:0] PWRUP_CYCLES = 20'd1000,
  parameter logic [19:0] SRST_CYCLES  = 20'd500,
  parameter int          MAX_RETRY    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [23:0]           rom_q,
  ov5640_init_sequencer_if.master sccb,
  output logic                  busy,
  output logic                  init_done,
  output logic                  init_err,
  output logic [ADDR_WIDTH-1:0] err_index
);

  // The retry counter must hold MAX_RETRY. It keeps at least one bit so
  // that MAX_RETRY = 0 (no retries) still gives a legal declaration.
  localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  localparam logic [RETRY_W-1:0]    MAX_RETRY_R = RETRY_W'(MAX_RETRY);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX    = ADDR_WIDTH'(INIT_NUM - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_PWRUP,
    S_FETCH,
    S_LATCH,
    S_REQ,
    S_GAP,
    S_SRST,
    S_NEXT,
    S_DONE,
    S_ERR
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] idx;
  logic [RETRY_W-1:0]    retry;
  logic [19:0]           delay_cnt;
  logic                  soft_reset_write;

  // A delay of N cycles ends on the cycle where count reaches N-1. The
  // compare is one bit wider so that N = 0 also ends after one cycle, and
  // the all-ones count cannot wrap around.
  function automatic logic delay_expired(input logic [19:0] count,
                                         input logic [19:0] limit);
    return ({1'b0, count} + 21'd1) >= {1'b0, limit};
  endfunction

  // The write that has just been acknowledged puts the sensor into
  // software reset. The sensor then needs settle time before the next
  // register access.
  assign soft_reset_write = (sccb.addr == 16'h3008) && sccb.data[7];

  // Main sequencer. Every output is a register set on the state
  // transition, so req/addr/data cannot glitch toward the SCCB master.
  // rom_addr is loaded when the FSM enters FETCH. The synchronous ROM then
  // has rom_q valid during LATCH, where it is captured. A start pulse is
  // seen only in IDLE/DONE/ERR. done/err from the master are looked at
  // only in REQ, so a stray done in any other state has no effect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      idx        <= '0;
      retry      <= '0;
      delay_cnt  <= '0;
      rom_addr   <= '0;
      sccb.req   <= 1'b0;
      sccb.addr  <= '0;
      sccb.data  <= '0;
      busy       <= 1'b0;
      init_done  <= 1'b0;
      init_err   <= 1'b0;
      err_index  <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            state     <= S_PWRUP;
            idx       <= '0;
            retry     <= '0;
            delay_cnt <= '0;
            rom_addr  <= '0;
            busy      <= 1'b1;
            init_done <= 1'b0;
            init_err  <= 1'b0;
            err_index <= '0;
          end
        end

        S_PWRUP: begin
          if (delay_expired(delay_cnt, PWRUP_CYCLES)) begin
            state     <= S_FETCH;
            rom_addr  <= idx;
            delay_cnt <= '0;
          end else begin
            delay_cnt <= delay_cnt + 20'd1;
          end
        end

        S_FETCH: begin
          state <= S_LATCH;
        end

        S_LATCH: begin
          sccb.addr <= rom_q[23:8];
          sccb.data <= rom_q[7:0];
          sccb.req  <= 1'b1;
          state     <= S_REQ;
        end

        // req drops on the edge that samples done. Both exits (GAP and
        // NEXT/SRST) give at least one low cycle before the next request.
        S_REQ: begin
          if (sccb.done) begin
            sccb.req <= 1'b0;
            if (!sccb.err) begin
              if (soft_reset_write) begin
                state     <= S_SRST;
                delay_cnt <= '0;
              end else begin
                state <= S_NEXT;
              end
            end else if (retry < MAX_RETRY_R) begin
              retry <= retry + RETRY_W'(1);
              state <= S_GAP;
            end else begin
              err_index <= idx;
              init_err  <= 1'b1;
              busy      <= 1'b0;
              state     <= S_ERR;
            end
          end
        end

        // One idle cycle, then re-issue. addr/data were not touched, so the
        // retry repeats exactly the same write.
        S_GAP: begin
          sccb.req <= 1'b1;
          state    <= S_REQ;
        end

        S_SRST: begin
          if (delay_expired(delay_cnt, SRST_CYCLES)) begin
            state     <= S_NEXT;
            delay_cnt <= '0;
          end else begin
            delay_cnt <= delay_cnt + 20'd1;
          end
        end

        // The last entry ends the walk here. idx and rom_addr never go past
        // INIT_NUM-1 and do not wrap.
        S_NEXT: begin
          retry <= '0;
          if (idx == LAST_IDX) begin
            init_done <= 1'b1;
            busy      <= 1'b0;
            state     <= S_DONE;
          end else begin
            idx      <= idx + ADDR_WIDTH'(1);
            rom_addr <= idx + ADDR_WIDTH'(1);
            state    <= S_FETCH;
          end
        end

        default: begin
          state    <= S_IDLE;
          sccb.req <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ov5640_init_sequencer.sv
// ---------------------------------------------------------------------------
// tb_ov5640_init_sequencer
//
// Purpose:
//   Directed bench for ov5640_init_sequencer, with INIT_NUM=4, PWRUP=3,
//   SRST=10 and MAX_RETRY=2. A synchronous ROM model holds four entries.
//   Entry 0 is a soft-reset write (0x3008 = 0x82) and entry 2 is 0x3008 =
//   0x02, which has no reset bit. An SCCB slave model acks five cycles after
//   each request edge and logs every write. It can inject a chosen number of
//   errors on one chosen entry.
// ---------------------------------------------------------------------------
module tb_ov5640_init_sequencer;

  localparam int ACK_DELAY = 5;
  localparam int LOG_MAX   = 32;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] rom_addr;
  logic [23:0] rom_q;
  logic       busy;
  logic       init_done;
  logic       init_err;
  logic [7:0] err_index;

  logic [23:0] rom_mem [0:3];

  int tests_run    = 0;
  int tests_failed = 0;
  int cycle        = 0;

  // Slave model state and write log
  int          n_writes   = 0;
  logic [15:0] log_addr [0:LOG_MAX-1];
  logic [7:0]  log_data [0:LOG_MAX-1];
  int          log_rise [0:LOG_MAX-1];
  int          log_done [0:LOG_MAX-1];
  int          err_entry  = -1;
  int          err_left   = 0;
  int          hold_viol  = 0;
  int          range_viol = 0;
  int          wait_cnt;
  logic        req_prev;
  logic        done_prev;

  ov5640_init_sequencer_if sccb_bus ();

  ov5640_init_sequencer #(
    .ADDR_WIDTH   (8),
    .INIT_NUM     (4),
    .PWRUP_CYCLES (20'd3),
    .SRST_CYCLES  (20'd10),
    .MAX_RETRY    (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .rom_addr  (rom_addr),
    .rom_q     (rom_q),
    .sccb      (sccb_bus.master),
    .busy      (busy),
    .init_done (init_done),
    .init_err  (init_err),
    .err_index (err_index)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cycle <= cycle + 1;

  // Synchronous ROM, one cycle of latency
  always @(posedge clk) rom_q <= (rom_addr < 8'd4) ? rom_mem[rom_addr[1:0]] : 24'h0;

  // SCCB slave model, driven on the falling edge
  initial begin
    sccb_bus.done = 1'b0;
    sccb_bus.err  = 1'b0;
    wait_cnt  = 0;
    req_prev  = 1'b0;
    done_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rom_addr > 8'd3) range_viol++;
      if (rst) begin
        sccb_bus.done = 1'b0;
        sccb_bus.err  = 1'b0;
        wait_cnt  = 0;
        req_prev  = 1'b0;
        done_prev = 1'b0;
      end else begin
        if (done_prev && sccb_bus.req) hold_viol++;
        done_prev     = 1'b0;
        sccb_bus.done = 1'b0;
        sccb_bus.err  = 1'b0;
        if (sccb_bus.req && !req_prev) begin
          if (n_writes < LOG_MAX) begin
            log_addr[n_writes] = sccb_bus.addr;
            log_data[n_writes] = sccb_bus.data;
            log_rise[n_writes] = cycle;
          end
          n_writes++;
          wait_cnt = 1;
        end else if (sccb_bus.req) begin
          wait_cnt++;
        end
        if (sccb_bus.req && wait_cnt == ACK_DELAY) begin
          sccb_bus.done = 1'b1;
          if (err_left > 0 && err_entry >= 0 &&
              {sccb_bus.addr, sccb_bus.data} == rom_mem[err_entry[1:0]]) begin
            sccb_bus.err = 1'b1;
            err_left--;
          end
          if (n_writes > 0 && n_writes <= LOG_MAX) log_done[n_writes-1] = cycle;
          wait_cnt  = 0;
          done_prev = 1'b1;
        end
        req_prev = sccb_bus.req;
      end
    end
  end

  task automatic pulse_start(output int start_cycle);
    @(negedge clk);
    start = 1'b1;
    start_cycle = cycle;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({sccb_bus.req, busy, init_done, init_err} !== 4'b0000) begin
      tests_failed++;
      $display("[TB] FAIL reset_flags: got %b expected 0000", {sccb_bus.req, busy, init_done, init_err});
    end
    tests_run++;
    if ({rom_addr, err_index, sccb_bus.addr, sccb_bus.data} !== 40'h0) begin
      tests_failed++;
      $display("[TB] FAIL reset_values: got %h expected 0", {rom_addr, err_index, sccb_bus.addr, sccb_bus.data});
    end
    rst = 1'b0;
    repeat (10) @(negedge clk);
    tests_run++;
    if (busy !== 1'b0 || n_writes !== 0) begin
      tests_failed++;
      $display("[TB] FAIL idle_without_start: busy %b writes %0d expected 0/0", busy, n_writes);
    end
  endtask

  task automatic test_full_sequence();
    int sc;
    n_writes = 0;
    pulse_start(sc);
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL busy_after_start: got %b expected 1", busy);
    end
    for (int i = 0; i < 400 && !init_done; i++) @(negedge clk);
    tests_run++;
    if (init_done !== 1'b1 || busy !== 1'b0 || init_err !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL seq_done: done/busy/err %b%b%b expected 100", init_done, busy, init_err);
    end
    tests_run++;
    if (n_writes !== 4) begin
      tests_failed++;
      $display("[TB] FAIL seq_count: got %0d writes expected 4", n_writes);
    end
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if ({log_addr[i], log_data[i]} !== rom_mem[i]) begin
        tests_failed++;
        $display("[TB] FAIL seq_entry%0d: got %h expected %h", i, {log_addr[i], log_data[i]}, rom_mem[i]);
      end
    end
    tests_run++;
    if (log_rise[0] - sc < 3) begin
      tests_failed++;
      $display("[TB] FAIL pwrup_delay: got %0d cycles expected >= 3", log_rise[0] - sc);
    end
    tests_run++;
    if (log_rise[1] - log_done[0] < 10) begin
      tests_failed++;
      $display("[TB] FAIL srst_delay: got %0d cycles expected >= 10", log_rise[1] - log_done[0]);
    end
    tests_run++;
    if (log_rise[3] - log_done[2] !== 4) begin
      tests_failed++;
      $display("[TB] FAIL no_srst_delay: got %0d cycles expected 4", log_rise[3] - log_done[2]);
    end
  endtask

  task automatic test_retry_once();
    int sc;
    int exp_idx [5] = '{0, 1, 2, 2, 3};
    n_writes  = 0;
    err_entry = 2;
    err_left  = 1;
    pulse_start(sc);
    tests_run++;
    if (init_done !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL done_cleared_on_restart: got %b expected 0", init_done);
    end
    for (int i = 0; i < 400 && !init_done && !init_err; i++) @(negedge clk);
    tests_run++;
    if (init_done !== 1'b1 || init_err !== 1'b0 || n_writes !== 5) begin
      tests_failed++;
      $display("[TB] FAIL retry_once_end: done %b err %b writes %0d expected 1 0 5", init_done, init_err, n_writes);
    end
    for (int i = 0; i < 5; i++) begin
      tests_run++;
      if ({log_addr[i], log_data[i]} !== rom_mem[exp_idx[i]]) begin
        tests_failed++;
        $display("[TB] FAIL retry_once_write%0d: got %h expected %h", i, {log_addr[i], log_data[i]}, rom_mem[exp_idx[i]]);
      end
    end
    tests_run++;
    if (log_rise[3] - log_done[2] !== 2) begin
      tests_failed++;
      $display("[TB] FAIL retry_gap: got %0d cycles expected 2", log_rise[3] - log_done[2]);
    end
    err_entry = -1;
  endtask

  task automatic test_retry_exhaust();
    int sc;
    n_writes  = 0;
    err_entry = 1;
    err_left  = 3;
    pulse_start(sc);
    for (int i = 0; i < 400 && !init_err && !init_done; i++) @(negedge clk);
    tests_run++;
    if (init_err !== 1'b1 || init_done !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL exhaust_flags: err/done/busy %b%b%b expected 100", init_err, init_done, busy);
    end
    tests_run++;
    if (err_index !== 8'd1) begin
      tests_failed++;
      $display("[TB] FAIL exhaust_err_index: got %0d expected 1", err_index);
    end
    repeat (40) @(negedge clk);
    tests_run++;
    if (n_writes !== 4 || sccb_bus.req !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL exhaust_attempts: writes %0d req %b expected 4 0", n_writes, sccb_bus.req);
    end
    for (int i = 1; i < 4; i++) begin
      tests_run++;
      if ({log_addr[i], log_data[i]} !== rom_mem[1]) begin
        tests_failed++;
        $display("[TB] FAIL exhaust_write%0d: got %h expected %h", i, {log_addr[i], log_data[i]}, rom_mem[1]);
      end
    end
    err_entry = -1;
    err_left  = 0;
  endtask

  task automatic test_async_reset();
    int sc;
    pulse_start(sc);
    for (int i = 0; i < 100 && !sccb_bus.req; i++) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    tests_run++;
    if (sccb_bus.req !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL async_reset_req: req %b busy %b expected 0 0", sccb_bus.req, busy);
    end
    @(negedge clk);
    rst = 1'b0;
    n_writes = 0;
    pulse_start(sc);
    for (int i = 0; i < 400 && !init_done; i++) @(negedge clk);
    tests_run++;
    if (init_done !== 1'b1 || n_writes !== 4) begin
      tests_failed++;
      $display("[TB] FAIL replay_after_reset: done %b writes %0d expected 1 4", init_done, n_writes);
    end
    tests_run++;
    if ({log_addr[0], log_data[0]} !== rom_mem[0]) begin
      tests_failed++;
      $display("[TB] FAIL replay_first_entry: got %h expected %h", {log_addr[0], log_data[0]}, rom_mem[0]);
    end
  endtask

  task automatic test_start_while_busy();
    int sc;
    int sc2;
    n_writes = 0;
    pulse_start(sc);
    for (int i = 0; i < 300 && n_writes < 3; i++) @(negedge clk);
    tests_run++;
    if (busy !== 1'b1 || init_done !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL busy_mid_run: busy %b done %b expected 1 0", busy, init_done);
    end
    pulse_start(sc2);
    for (int i = 0; i < 400 && !init_done; i++) @(negedge clk);
    tests_run++;
    if (init_done !== 1'b1 || n_writes !== 4) begin
      tests_failed++;
      $display("[TB] FAIL start_ignored: done %b writes %0d expected 1 4", init_done, n_writes);
    end
    tests_run++;
    if (hold_viol !== 0 || range_viol !== 0) begin
      tests_failed++;
      $display("[TB] FAIL protocol: req-after-done %0d rom_addr-range %0d expected 0 0", hold_viol, range_viol);
    end
  endtask

  initial begin
    rom_mem[0] = 24'h3008_82;
    rom_mem[1] = 24'h3103_11;
    rom_mem[2] = 24'h3008_02;
    rom_mem[3] = 24'h3017_FF;
    rst   = 1'b1;
    start = 1'b0;
    test_reset();
    test_full_sequence();
    test_retry_once();
    test_retry_exhaust();
    test_async_reset();
    test_start_while_busy();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
